// File: rtl/thiele_mu_core.sv
// Thiele core with valid/ready instruction fetch, FETCH/EXEC/HALT sequencing,
// a saturating total mu accumulator and one saturating mu ledger per partition module.
module thiele_mu_core #(
   parameter int MU_W        = 32,
   parameter int NUM_MODULES = 4,
   parameter int PC_STEP     = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [31:0]     instr_data,
   output logic            instr_ready,
   output logic [31:0]     pc,
   output logic [MU_W-1:0] mu_cost,
   input  logic [3:0]      mu_rd_sel,
   output logic [MU_W-1:0] mu_rd_data,
   output logic            mu_overflow,
   output logic            error,
   output logic            halted
);

   // state    | meaning
   // ST_FETCH | waiting for instr_valid, instr_ready high
   // ST_EXEC  | executing the latched IR this cycle
   // ST_HALT  | terminal until reset, all state held
   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

   localparam logic [5:0] OP_ADD    = 6'd0;
   localparam logic [5:0] OP_SUB    = 6'd1;
   localparam logic [5:0] OP_CLAIM  = 6'd2;
   localparam logic [5:0] OP_CHARGE = 6'd3;
   localparam logic [5:0] OP_JUMP   = 6'd4;
   localparam logic [5:0] OP_HALT   = 6'd5;

   // Sum width holds either operand plus a carry, so the saturation compare is exact.
   localparam int SW = ((MU_W > 22) ? MU_W : 22) + 1;
   localparam logic [SW-1:0] MU_MAX = {{(SW-MU_W){1'b0}}, {MU_W{1'b1}}};

   function automatic logic [MU_W:0] sat_add(input logic [MU_W-1:0] a, input logic [SW-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + b;
      if (s > MU_MAX) return {1'b1, {MU_W{1'b1}}};
      else            return {1'b0, s[MU_W-1:0]};
   endfunction

   state_t            state_q, state_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       pc_q, pc_d;
   logic [MU_W-1:0]   total_q, total_d;
   logic [MU_W-1:0]   ledger_q [NUM_MODULES];
   logic [MU_W-1:0]   ledger_d [NUM_MODULES];
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;

   logic [5:0]        op;
   logic [3:0]        mid;
   logic [SW-1:0]     imm_ext;
   logic [SW-1:0]     inc;
   logic              mod_ok;
   logic              sat_tot;
   logic              sat_led;
   logic [31:0]       pc_seq;

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      total_d = total_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      for (int i = 0; i < NUM_MODULES; i++) ledger_d[i] = ledger_q[i];
      sat_tot = 1'b0;
      sat_led = 1'b0;
      op      = ir_q[5:0];
      mid     = ir_q[9:6];
      imm_ext = SW'(ir_q[31:10]);
      mod_ok  = int'(mid) < NUM_MODULES;
      pc_seq  = pc_q + 32'(PC_STEP);
      inc     = (op == OP_CLAIM) ? SW'(1) : imm_ext;

      unique case (state_q)
         ST_FETCH: begin
            if (instr_valid) begin
               ir_d    = instr_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (op)
               OP_ADD: begin
                  {sat_tot, total_d} = sat_add(total_q, imm_ext);
                  ovf_d = ovf_q | sat_tot;
                  pc_d  = pc_seq;
               end
               OP_SUB: begin
                  // Floors at zero silently; underflow is not an overflow event.
                  if (imm_ext < SW'(total_q)) total_d = total_q - MU_W'(imm_ext);
                  else                        total_d = '0;
                  pc_d = pc_seq;
               end
               OP_CLAIM, OP_CHARGE: begin
                  if (!mod_ok) begin
                     err_d   = 1'b1;
                     state_d = ST_HALT;
                  end else begin
                     {sat_tot, total_d} = sat_add(total_q, inc);
                     for (int i = 0; i < NUM_MODULES; i++) begin
                        if (mid == 4'(i)) {sat_led, ledger_d[i]} = sat_add(ledger_q[i], inc);
                     end
                     ovf_d = ovf_q | sat_tot | sat_led;
                     pc_d  = pc_seq;
                  end
               end
               OP_JUMP: pc_d = {8'b0, ir_q[31:10], 2'b00};
               OP_HALT: state_d = ST_HALT;
               default: pc_d = pc_seq;
            endcase
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         pc_q    <= '0;
         total_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_MODULES; i++) ledger_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         total_q <= total_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         for (int i = 0; i < NUM_MODULES; i++) ledger_q[i] <= ledger_d[i];
      end
   end

   always_comb begin
      mu_rd_data = '0;
      for (int i = 0; i < NUM_MODULES; i++) begin
         if (mu_rd_sel == 4'(i)) mu_rd_data = ledger_q[i];
      end
   end

   assign instr_ready = (state_q == ST_FETCH);
   assign halted      = (state_q == ST_HALT);
   assign pc          = pc_q;
   assign mu_cost     = total_q;
   assign mu_overflow = ovf_q;
   assign error       = err_q;

endmodule

// File: tb/tb_thiele_mu_core.sv
// Directed plus randomized bench for thiele_mu_core against an arithmetic reference model.
module tb_thiele_mu_core;
   localparam int MW = 8;
   localparam int NM = 4;
   localparam longint MAXV = (64'd1 << MW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic [31:0]   instr_data = '0;
   logic          instr_ready;
   logic [31:0]   pc;
   logic [MW-1:0] mu_cost;
   logic [3:0]    mu_rd_sel = '0;
   logic [MW-1:0] mu_rd_data;
   logic          mu_overflow;
   logic          error;
   logic          halted;

   int tests = 0;
   int fails = 0;

   longint      m_total;
   longint      m_led [16];
   int unsigned m_pc;
   bit          m_ovf, m_err, m_halt;

   thiele_mu_core #(.MU_W(MW), .NUM_MODULES(NM), .PC_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_data(instr_data),
      .instr_ready(instr_ready), .pc(pc), .mu_cost(mu_cost), .mu_rd_sel(mu_rd_sel),
      .mu_rd_data(mu_rd_data), .mu_overflow(mu_overflow), .error(error), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint a, input longint b);
      if (a + b > MAXV) begin
         m_ovf = 1'b1;
         return MAXV;
      end
      return a + b;
   endfunction

   function automatic void model_reset();
      m_total = 0;
      for (int i = 0; i < 16; i++) m_led[i] = 0;
      m_pc = 0; m_ovf = 0; m_err = 0; m_halt = 0;
   endfunction

   function automatic void model_exec(input int op, input int mid, input int imm);
      if ((op == 2 || op == 3) && mid >= NM) begin
         m_err = 1; m_halt = 1;
         return;
      end
      case (op)
         0: m_total = sat(m_total, imm);
         1: m_total = (imm >= m_total) ? 0 : m_total - imm;
         2: begin m_total = sat(m_total, 1); m_led[mid] = sat(m_led[mid], 1); end
         3: begin m_total = sat(m_total, imm); m_led[mid] = sat(m_led[mid], imm); end
         4: m_pc = imm * 4;
         5: m_halt = 1;
         default: ;
      endcase
      if (op != 4 && op != 5) m_pc = m_pc + 4;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
      chk({tag, "_mu"}, 64'(mu_cost), 64'(m_total));
      chk({tag, "_ovf"}, 64'(mu_overflow), 64'(m_ovf));
      chk({tag, "_err"}, 64'(error), 64'(m_err));
      chk({tag, "_halted"}, 64'(halted), 64'(m_halt));
      chk({tag, "_ready"}, 64'(instr_ready), 64'(!m_halt));
      for (int s = 0; s < 16; s++) begin
         mu_rd_sel = 4'(s);
         #1;
         chk({tag, "_ledger"}, 64'(mu_rd_data), 64'(m_led[s]));
      end
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #3;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input string tag, input int op, input int mid, input int imm);
      logic [31:0] w;
      w = {imm[21:0], mid[3:0], op[5:0]};
      @(negedge clk);
      chk({tag, "_ready_fetch"}, 64'(instr_ready), 64'd1);
      instr_valid = 1'b1;
      instr_data  = w;
      @(posedge clk); #1;
      chk({tag, "_ready_exec"}, 64'(instr_ready), 64'd0);
      instr_valid = 1'b0;
      instr_data  = $urandom;
      @(posedge clk); #1;
      model_exec(op, mid, imm);
      check_all(tag);
   endtask

   initial begin
      int r, op, mid, imm;
      logic [31:0] w;

      do_reset();
      #1;
      check_all("reset");

      send("add10", 0, 0, 10);
      chk("add10_mu_abs", 64'(mu_cost), 64'd10);
      send("sub3", 1, 0, 3);
      chk("sub3_mu_abs", 64'(mu_cost), 64'd7);
      send("claim2", 2, 2, 0);
      chk("claim2_mu_abs", 64'(mu_cost), 64'd8);
      chk("claim2_pc_abs", 64'(pc), 64'd12);

      do_reset();
      send("add5", 0, 0, 5);
      send("sub_floor", 1, 0, 100);
      chk("sub_floor_abs", 64'(mu_cost), 64'd0);

      do_reset();
      send("charge_a", 3, 1, 200);
      send("charge_b", 3, 1, 200);
      chk("charge_sat_abs", 64'(mu_cost), 64'd255);
      send("add_sat", 0, 0, 1);

      do_reset();
      send("jump", 4, 0, 'h40);
      chk("jump_pc_abs", 64'(pc), 64'h100);
      send("add_after_jump", 0, 0, 2);
      send("halt", 5, 0, 0);
      @(negedge clk);
      instr_valid = 1'b1;
      instr_data  = {22'd9, 4'd0, 6'd0};
      repeat (6) @(posedge clk);
      #1;
      instr_valid = 1'b0;
      check_all("halt_hold");

      do_reset();
      send("pre_err", 0, 0, 3);
      send("bad_mod", 3, 5, 7);
      mu_rd_sel = 4'd5; #1;
      chk("bad_mod_rd5", 64'(mu_rd_data), 64'd0);

      do_reset();
      send("pre_abort", 0, 0, 4);
      @(negedge clk);
      instr_valid = 1'b1;
      instr_data  = {22'd9, 4'd1, 6'd3};
      @(posedge clk); #2;
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("abort");
      @(negedge clk);
      rst_n = 1'b1;
      send("post_abort", 0, 0, 2);

      do_reset();
      for (int n = 0; n < 150; n++) begin
         r   = $urandom_range(0, 99);
         mid = $urandom_range(0, NM - 1);
         imm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 22'h3FFFFF))
                                           : int'($urandom_range(0, 60));
         if      (r < 20) op = 0;
         else if (r < 35) op = 1;
         else if (r < 55) op = 2;
         else if (r < 75) op = 3;
         else if (r < 82) op = 4;
         else if (r < 84) op = 5;
         else if (r < 87) begin op = 3; mid = $urandom_range(NM, 15); end
         else             op = $urandom_range(6, 63);
         send("rand", op, mid, imm);
         if (m_halt) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/thiele_mu_core.md
# thiele_mu_core

Parametrised successor to the minimal Thiele core. It adds a valid/ready instruction fetch handshake and a two-phase FETCH/EXEC/HALT state machine. μ-cost is tracked as a saturating total plus one saturating μ-ledger per partition module, with a readback port. It sits between the instruction source (ROM/bus adapter) and the μ-cost reporting logic.

## Interface
- MU_W, 32, width of total and per-module μ counters (8..64)
- NUM_MODULES, 4, number of partition-module ledgers (1..16)
- PC_STEP, 4, PC increment per executed instruction

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- instr_valid  input  1  instr_data holds a valid instruction
- instr_data  input  32  [5:0] opcode, [9:6] module id, [31:10] imm (22 b, zero-extended)
- instr_ready  output  1  core accepts an instruction this cycle
- pc  output  32  address of next instruction
- mu_cost  output  MU_W  total μ accumulator
- mu_rd_sel  input  4  module ledger select
- mu_rd_data  output  MU_W  ledger[mu_rd_sel], combinational; 0 if sel ≥ NUM_MODULES
- mu_overflow  output  1  sticky: some μ addition saturated
- error  output  1  sticky: illegal module id executed
- halted  output  1  core in HALT

## Operation
- States: FETCH, EXEC, HALT. Reset enters FETCH.
- instr_ready = (state == FETCH). It is 0 in EXEC and HALT.
- FETCH: on instr_valid && instr_ready, latch instr_data into IR and go to EXEC. Otherwise stay in FETCH.
- EXEC executes IR in one cycle, then goes to FETCH, or to HALT for HALT/error.
- Opcodes:
  - 0 ADD: total += imm.
  - 1 SUB: total = max(total − imm, 0). Floors at 0 and never sets a flag.
  - 2 CLAIM: total += 1 and ledger[m] += 1.
  - 3 CHARGE: total += imm and ledger[m] += imm.
  - 4 JUMP: pc = {8'b0, imm, 2'b00}[31:0].
  - 5 HALT: pc unchanged, go to HALT.
  - Any other opcode is a NOP.
- pc += PC_STEP after every executed instruction except JUMP, HALT and error. pc is 32 b and wraps modulo 2^32.
- Saturating add:
  - If the result exceeds 2^MU_W − 1, the counter holds all-ones and mu_overflow is set.
  - For CLAIM/CHARGE, total and ledger saturate independently. Either one saturating sets the flag.
- Module id m ≥ NUM_MODULES on CLAIM/CHARGE:
  - No μ or pc update.
  - error is set and the core goes to HALT.
  - The id field is ignored for all other opcodes.
- HALT is terminal until rst_n is asserted: no fetch, and all state is held.
- mu_overflow and error clear only on reset.

## Timing
- Reset values:
  - pc 0, mu_cost 0, all ledgers 0.
  - mu_overflow 0, error 0, halted 0.
  - instr_ready 1 (state FETCH).
- An instruction accepted at edge N updates pc/μ/flags at edge N+1. Results are visible after N+1.
- Throughput: one instruction per 2 cycles with instr_valid held high. The next accept is at edge N+2.
- instr_data is sampled only on the accept edge. The source may change it freely while instr_ready = 0.
- halted rises at the EXEC edge of HALT/error. instr_ready is 0 from that cycle on.
- mu_rd_data reflects ledger updates in the cycle after the EXEC edge (zero-cycle read path).
- Asynchronous reset mid-EXEC aborts the instruction with no partial update. All state returns to reset values immediately.

## Test plan
- Reset, then ADD imm=10, SUB imm=3, CLAIM m=2 -> mu_cost 10, 7, 8. ledger[2]=1. pc=12. instr_ready toggles 1,0 per instruction.
- SUB imm=100 with total=5 -> mu_cost 0, mu_overflow stays 0.
- MU_W=8: CHARGE m=1 imm=200 twice -> mu_cost 255, ledger[1]=255, mu_overflow=1. Further ADD imm=1 -> stays 255.
- JUMP imm=0x40 -> pc 0x100. Next ADD -> pc 0x104. HALT -> pc unchanged, halted=1, instr_ready=0, later instr_valid ignored.
- NUM_MODULES=4, CHARGE m=5 imm=7 -> error=1, halted=1, mu_cost and pc unchanged. mu_rd_sel=5 -> mu_rd_data 0.
- Assert rst_n low during EXEC of CHARGE imm=9 -> mu_cost 0, ledgers 0, pc 0, flags 0. After release, instr_ready=1 and the next instruction executes normally.
